// File: rtl/mcu_multicycle.sv
// rtl/mcu_multicycle.sv - multi-cycle main control FSM for the MIPS core
package mcu_multicycle_pkg;
  typedef enum logic [2:0] {
    ALU_AND  = 3'd0,
    ALU_OR   = 3'd1,
    ALU_ADD  = 3'd2,
    ALU_ADDU = 3'd3,
    ALU_SUBU = 3'd4,
    ALU_SLT  = 3'd5
  } alu_op_t;
endpackage

module mcu_multicycle
  import mcu_multicycle_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             addu,
  input  logic             subu,
  input  logic             ori,
  input  logic             lw,
  input  logic             sw,
  input  logic             beq,
  input  logic             lui,
  input  logic             addi,
  input  logic             addiu,
  input  logic             slt,
  input  logic             j,
  input  logic             jal,
  input  logic             jr,
  input  logic             zero,
  input  logic             mem_ready,
  output logic [2:0]       state,
  output logic             mem_req,
  output logic             mem_we,
  output logic             IorD,
  output logic             IRWr,
  output logic             PCWr,
  output logic [1:0]       PcSrc,
  output logic             RegWrite,
  output logic [1:0]       RegDst,
  output logic [1:0]       MemtoReg,
  output logic             ALUsrc,
  output alu_op_t          ALUctr,
  output logic [1:0]       ExtOp,
  output logic             instr_done,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  state_t cur, nxt;

  logic any_flag;
  logic jump_any;
  logic sel_j, sel_jal, sel_jr, sel_beq, sel_lw, sel_sw;

  // Priority when several decode flags are set: j, jal, jr, beq, lw, sw, rest.
  assign any_flag = addu | subu | ori | lw | sw | beq | lui | addi | addiu | slt | j | jal | jr;
  assign jump_any = j | jal | jr;
  assign sel_j    = j;
  assign sel_jal  = jal & ~j;
  assign sel_jr   = jr & ~j & ~jal;
  assign sel_beq  = beq & ~jump_any;
  assign sel_lw   = lw & ~jump_any & ~beq;
  assign sel_sw   = sw & ~jump_any & ~beq & ~lw;

  assign state = cur;

  always_ff @(posedge clk) begin
    if (reset) begin
      cur <= S_FETCH;
    end else begin
      cur <= nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_cnt <= '0;
    end else if (instr_done) begin
      instr_cnt <= instr_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    ALUsrc = ori | lw | sw | addi | addiu | lui;
    if (ori) begin
      ExtOp = 2'd0;
    end else if (lui) begin
      ExtOp = 2'd1;
    end else begin
      ExtOp = 2'd2;
    end
    if (ori) begin
      ALUctr = ALU_OR;
    end else if (lw | sw | addi) begin
      ALUctr = ALU_ADD;
    end else if (slt) begin
      ALUctr = ALU_SLT;
    end else if (addu | addiu) begin
      ALUctr = ALU_ADDU;
    end else if (subu | beq) begin
      ALUctr = ALU_SUBU;
    end else begin
      ALUctr = ALU_AND;
    end
  end

  always_comb begin
    nxt        = cur;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    IorD       = 1'b0;
    IRWr       = 1'b0;
    PCWr       = 1'b0;
    PcSrc      = 2'd0;
    RegWrite   = 1'b0;
    RegDst     = 2'd0;
    MemtoReg   = 2'd0;
    instr_done = 1'b0;
    illegal    = 1'b0;

    case (cur)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          IRWr = 1'b1;
          PCWr = 1'b1;
          nxt  = S_DECODE;
        end
      end
      S_DECODE: begin
        if (sel_j | sel_jal) begin
          PCWr       = 1'b1;
          PcSrc      = 2'd2;
          instr_done = 1'b1;
          nxt        = S_FETCH;
          if (sel_jal) begin
            RegWrite = 1'b1;
            RegDst   = 2'd2;
            MemtoReg = 2'd2;
          end
        end else if (sel_jr) begin
          PCWr       = 1'b1;
          PcSrc      = 2'd3;
          instr_done = 1'b1;
          nxt        = S_FETCH;
        end else if (!any_flag) begin
          illegal = 1'b1;
          nxt     = S_FETCH;
        end else begin
          nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        if (sel_beq) begin
          PcSrc      = 2'd1;
          PCWr       = zero;
          instr_done = 1'b1;
          nxt        = S_FETCH;
        end else if (sel_lw | sel_sw) begin
          nxt = S_MEM;
        end else begin
          nxt = S_WB;
        end
      end
      S_MEM: begin
        // mem_we is held for the whole wait so the store is issued exactly once.
        mem_req = 1'b1;
        IorD    = 1'b1;
        mem_we  = sel_sw;
        if (mem_ready) begin
          if (sel_sw) begin
            instr_done = 1'b1;
            nxt        = S_FETCH;
          end else begin
            nxt = S_WB;
          end
        end
      end
      S_WB: begin
        RegWrite   = 1'b1;
        RegDst     = (addu | subu | slt) ? 2'd1 : 2'd0;
        if (lw) begin
          MemtoReg = 2'd1;
        end else if (lui) begin
          MemtoReg = 2'd3;
        end
        instr_done = 1'b1;
        nxt        = S_FETCH;
      end
      default: begin
        nxt = S_FETCH;
      end
    endcase

    if (reset) begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      IRWr       = 1'b0;
      PCWr       = 1'b0;
      RegWrite   = 1'b0;
      instr_done = 1'b0;
      illegal    = 1'b0;
    end
  end

endmodule

// File: tb/tb_mcu_multicycle.sv
// tb/tb_mcu_multicycle.sv - self-checking bench for mcu_multicycle
module tb_mcu_multicycle;
  import mcu_multicycle_pkg::*;

  localparam int CNT_W = 4;
  localparam logic [12:0] I_ADDU = 13'd1 << 0, I_SUBU = 13'd1 << 1, I_ORI = 13'd1 << 2,
    I_LW = 13'd1 << 3, I_SW = 13'd1 << 4, I_BEQ = 13'd1 << 5, I_LUI = 13'd1 << 6,
    I_ADDI = 13'd1 << 7, I_ADDIU = 13'd1 << 8, I_SLT = 13'd1 << 9, I_J = 13'd1 << 10,
    I_JAL = 13'd1 << 11, I_JR = 13'd1 << 12;

  logic clk = 1'b0;
  logic reset, zero, mem_ready;
  logic [12:0] fl;
  logic [2:0] state;
  logic mem_req, mem_we, IorD, IRWr, PCWr, RegWrite, ALUsrc, instr_done, illegal;
  logic [1:0] PcSrc, RegDst, MemtoReg, ExtOp;
  alu_op_t ALUctr;
  logic [CNT_W-1:0] instr_cnt;

  mcu_multicycle #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .addu(fl[0]), .subu(fl[1]), .ori(fl[2]), .lw(fl[3]), .sw(fl[4]), .beq(fl[5]),
    .lui(fl[6]), .addi(fl[7]), .addiu(fl[8]), .slt(fl[9]), .j(fl[10]), .jal(fl[11]),
    .jr(fl[12]), .zero(zero), .mem_ready(mem_ready),
    .state(state), .mem_req(mem_req), .mem_we(mem_we), .IorD(IorD), .IRWr(IRWr),
    .PCWr(PCWr), .PcSrc(PcSrc), .RegWrite(RegWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .ALUsrc(ALUsrc), .ALUctr(ALUctr), .ExtOp(ExtOp),
    .instr_done(instr_done), .illegal(illegal), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic req, we, iord, irwr, pcwr;
    logic [1:0] pcsrc;
    logic rw;
    logic [1:0] rdst, m2r;
    logic done, ill;
  } exp_t;

  exp_t exp_cur;
  logic chk_on = 1'b0;
  logic idle_rdy = 1'b1;
  int n_chk = 0, n_fail = 0, model_cnt = 0, ncyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, want, $time);
    end
  endtask

  function automatic logic [2:0] alu_model(input logic [12:0] f);
    if (f & I_ORI) return 3'(ALU_OR);
    if (f & (I_LW | I_SW | I_ADDI)) return 3'(ALU_ADD);
    if (f & I_SLT) return 3'(ALU_SLT);
    if (f & (I_ADDU | I_ADDIU)) return 3'(ALU_ADDU);
    if (f & (I_SUBU | I_BEQ)) return 3'(ALU_SUBU);
    return 3'(ALU_AND);
  endfunction

  function automatic logic [1:0] ext_model(input logic [12:0] f);
    if (f & I_ORI) return 2'd0;
    if (f & I_LUI) return 2'd1;
    return 2'd2;
  endfunction

  always @(negedge clk) begin
    if (chk_on) begin
      chk("state", 32'(state), 32'(exp_cur.st));
      chk("mem_req", 32'(mem_req), 32'(exp_cur.req));
      chk("mem_we", 32'(mem_we), 32'(exp_cur.we));
      chk("IorD", 32'(IorD), 32'(exp_cur.iord));
      chk("IRWr", 32'(IRWr), 32'(exp_cur.irwr));
      chk("PCWr", 32'(PCWr), 32'(exp_cur.pcwr));
      chk("PcSrc", 32'(PcSrc), 32'(exp_cur.pcsrc));
      chk("RegWrite", 32'(RegWrite), 32'(exp_cur.rw));
      chk("RegDst", 32'(RegDst), 32'(exp_cur.rdst));
      chk("MemtoReg", 32'(MemtoReg), 32'(exp_cur.m2r));
      chk("instr_done", 32'(instr_done), 32'(exp_cur.done));
      chk("illegal", 32'(illegal), 32'(exp_cur.ill));
      chk("instr_cnt", 32'(instr_cnt), 32'(model_cnt % (1 << CNT_W)));
      chk("ALUsrc", 32'(ALUsrc), 32'((fl & (I_ORI | I_LW | I_SW | I_ADDI | I_ADDIU | I_LUI)) != 0));
      chk("ExtOp", 32'(ExtOp), 32'(ext_model(fl)));
      chk("ALUctr", 32'(ALUctr), 32'(alu_model(fl)));
    end
  end

  function automatic exp_t mk(input logic [2:0] s);
    exp_t e;
    e = '0;
    e.st = s;
    return e;
  endfunction

  task automatic step(input exp_t e, input logic rdy, input logic rst);
    mem_ready = rdy;
    reset = rst;
    exp_cur = e;
    chk_on = 1'b1;
    @(posedge clk);
    #1;
    if (rst) model_cnt = 0;
    else if (e.done) model_cnt++;
    ncyc++;
  endtask

  // Expected trace is built from the instruction class and the memory wait counts.
  task automatic run_instr(input logic [12:0] f, input logic z, input int fw, input int mw,
                           output int cyc);
    exp_t e;
    int start;
    string k;
    start = ncyc;
    fl = f;
    zero = z;
    if (f & I_J) k = "j";
    else if (f & I_JAL) k = "jal";
    else if (f & I_JR) k = "jr";
    else if (f & I_BEQ) k = "beq";
    else if (f & I_LW) k = "lw";
    else if (f & I_SW) k = "sw";
    else if (f != 0) k = "alu";
    else k = "ill";

    for (int i = 0; i < fw; i++) begin
      e = mk(3'd0); e.req = 1'b1;
      step(e, 1'b0, 1'b0);
    end
    e = mk(3'd0); e.req = 1'b1; e.irwr = 1'b1; e.pcwr = 1'b1;
    step(e, 1'b1, 1'b0);

    e = mk(3'd1);
    if (k == "j" || k == "jal") begin
      e.pcwr = 1'b1; e.pcsrc = 2'd2; e.done = 1'b1;
      if (k == "jal") begin e.rw = 1'b1; e.rdst = 2'd2; e.m2r = 2'd2; end
    end else if (k == "jr") begin
      e.pcwr = 1'b1; e.pcsrc = 2'd3; e.done = 1'b1;
    end else if (k == "ill") begin
      e.ill = 1'b1;
    end
    step(e, idle_rdy, 1'b0);

    if (k != "j" && k != "jal" && k != "jr" && k != "ill") begin
      e = mk(3'd2);
      if (k == "beq") begin
        e.pcsrc = 2'd1; e.pcwr = z; e.done = 1'b1;
      end
      step(e, idle_rdy, 1'b0);
      if (k == "lw" || k == "sw") begin
        e = mk(3'd3); e.req = 1'b1; e.iord = 1'b1; e.we = (k == "sw");
        for (int i = 0; i < mw; i++) step(e, 1'b0, 1'b0);
        e.done = (k == "sw");
        step(e, 1'b1, 1'b0);
      end
      if (k == "lw" || k == "alu") begin
        e = mk(3'd4); e.rw = 1'b1; e.done = 1'b1;
        e.rdst = ((f & (I_ADDU | I_SUBU | I_SLT)) != 0) ? 2'd1 : 2'd0;
        e.m2r = (k == "lw") ? 2'd1 : ((f & I_LUI) != 0) ? 2'd3 : 2'd0;
        step(e, idle_rdy, 1'b0);
      end
    end
    cyc = ncyc - start;
  endtask

  initial begin
    int c;
    exp_t e;
    fl = '0; zero = 1'b0; mem_ready = 1'b0; reset = 1'b1;
    @(posedge clk);
    #1;
    step(mk(3'd0), 1'b0, 1'b1);

    run_instr(I_ADDU, 1'b0, 0, 0, c);
    chk("addu_cycles", 32'(c), 32'd4);
    chk("cnt_after_addu", 32'(instr_cnt), 32'd1);
    idle_rdy = 1'b0;

    run_instr(I_LW, 1'b0, 3, 3, c);
    chk("lw_wait_cycles", 32'(c), 32'd11);
    run_instr(I_BEQ, 1'b1, 0, 0, c);
    chk("beq_taken_cycles", 32'(c), 32'd3);
    run_instr(I_BEQ, 1'b0, 0, 0, c);
    chk("beq_nt_cycles", 32'(c), 32'd3);
    chk("cnt_after_beq", 32'(instr_cnt), 32'd4);
    run_instr(I_JAL, 1'b0, 0, 0, c);
    chk("jal_cycles", 32'(c), 32'd2);
    run_instr(13'd0, 1'b0, 0, 0, c);
    chk("cnt_after_illegal", 32'(instr_cnt), 32'd5);

    run_instr(I_SUBU, 1'b1, 0, 0, c);
    run_instr(I_SLT, 1'b0, 1, 0, c);
    run_instr(I_ORI, 1'b0, 0, 0, c);
    run_instr(I_LUI, 1'b0, 0, 0, c);
    run_instr(I_ADDI, 1'b0, 0, 0, c);
    run_instr(I_ADDIU, 1'b0, 0, 0, c);
    run_instr(I_SW, 1'b0, 1, 2, c);
    chk("sw_wait_cycles", 32'(c), 32'd7);
    run_instr(I_J, 1'b0, 0, 0, c);
    run_instr(I_JR, 1'b0, 0, 0, c);
    run_instr(I_J | I_BEQ, 1'b1, 0, 0, c);
    chk("prio_j_cycles", 32'(c), 32'd2);
    run_instr(I_LW | I_SW, 1'b0, 0, 1, c);
    chk("prio_lw_cycles", 32'(c), 32'd6);
    chk("cnt_wrap_mid", 32'(instr_cnt), 32'd0);

    fl = I_SW; zero = 1'b0;
    e = mk(3'd0); e.req = 1'b1; e.irwr = 1'b1; e.pcwr = 1'b1;
    step(e, 1'b1, 1'b0);
    step(mk(3'd1), 1'b0, 1'b0);
    step(mk(3'd2), 1'b0, 1'b0);
    e = mk(3'd3); e.req = 1'b1; e.iord = 1'b1; e.we = 1'b1;
    step(e, 1'b0, 1'b0);
    e = mk(3'd3); e.iord = 1'b1;
    step(e, 1'b0, 1'b1);
    e = mk(3'd0); e.req = 1'b1;
    step(e, 1'b0, 1'b0);
    chk("cnt_after_reset", 32'(instr_cnt), 32'd0);

    for (int i = 0; i < 16; i++) begin
      run_instr(I_ORI, 1'b0, 0, 0, c);
      if (i == 14) chk("cnt_at_15", 32'(instr_cnt), 32'd15);
    end
    chk("cnt_wrap_ori", 32'(instr_cnt), 32'd0);

    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
